// File: rtl/adc_multi_ch_avg.sv
// adc_multi_ch_avg: multi-channel XADC sequencer readout with per-slot block averaging.
// Each in-range end-of-conversion edge starts one DRP read. The truncated sample
// goes into that channel slot's power-of-two accumulator. The latest average of any
// slot can be selected for downstream display logic.
// Optional build macro: ADC_PEAK_HOLD_EN adds per-slot raw-sample peak registers,
// the sel_peak output and the peak_clr input.
module adc_multi_ch_avg #(
  parameter int         NUM_CH   = 4,
  parameter logic [4:0] CH_BASE  = 5'd22,
  parameter int         OUT_W    = 12,
  parameter int         AVG_LOG2 = 2,
  parameter int         TIMEOUT  = 64,
  parameter int         CH_W     = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              eoc_in,
  input  logic [4:0]        channel_in,
  output logic              den_out,
  output logic [6:0]        daddr_out,
  input  logic              drdy_in,
  input  logic [15:0]       do_in,
  input  logic [CH_W-1:0]   sel_ch,
  output logic [OUT_W-1:0]  sel_value,
  output logic              sel_valid,
  output logic              sample_strobe,
  output logic [CH_W-1:0]   sample_ch,
  output logic              err_timeout,
  output logic              err_overrun
`ifdef ADC_PEAK_HOLD_EN
  ,
  input  logic              peak_clr,
  output logic [OUT_W-1:0]  sel_peak
`endif
);

  localparam int ACC_W = OUT_W + AVG_LOG2;
  // A zero-width counter is not legal, so pass-through mode keeps one bit that never moves.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_ACCUM = 2'd3
  } state_t;

  state_t           state_r;
  logic             eoc_d_r;
  logic [CH_W-1:0]  slot_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [OUT_W-1:0] sample_r;
  logic [ACC_W-1:0] acc_r    [NUM_CH];
  logic [CNT_W-1:0] cnt_r    [NUM_CH];
  logic [OUT_W-1:0] result_r [NUM_CH];
  logic             valid_r  [NUM_CH];

  logic             eoc_edge_s;
  logic [5:0]       ch_off_s;
  logic             in_range_s;
  logic [CH_W-1:0]  slot_s;
  logic [ACC_W-1:0] sum_s;
  logic [OUT_W-1:0] avg_s;

  // Edge detect, channel window check and the accumulator datapath for the active slot.
  always_comb begin
    eoc_edge_s = eoc_in & ~eoc_d_r;
    // Below-base channels wrap to large offsets in 6 bits, so one compare covers both ends.
    ch_off_s   = {1'b0, channel_in} - {1'b0, CH_BASE};
    in_range_s = (ch_off_s < 6'(NUM_CH));
    slot_s     = CH_W'(ch_off_s);
    sum_s      = acc_r[slot_r] + ACC_W'(sample_r);
    avg_s      = OUT_W'(sum_s >> AVG_LOG2);
  end

  // Register eoc once so that a level held across cycles starts only one read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      eoc_d_r <= 1'b0;
    end else begin
      eoc_d_r <= eoc_in;
    end
  end

  // Read-sequence FSM with DRP handshake, timeout, per-slot accumulation and error flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r       <= S_IDLE;
      slot_r        <= '0;
      tmo_cnt_r     <= '0;
      sample_r      <= '0;
      den_out       <= 1'b0;
      daddr_out     <= 7'd0;
      sample_strobe <= 1'b0;
      sample_ch     <= '0;
      err_timeout   <= 1'b0;
      err_overrun   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc_r[i]    <= '0;
        cnt_r[i]    <= '0;
        result_r[i] <= '0;
        valid_r[i]  <= 1'b0;
      end
    end else begin
      den_out       <= 1'b0;
      sample_strobe <= 1'b0;
      // No queueing: a conversion reported while a read is in flight is lost.
      if (eoc_edge_s && (state_r != S_IDLE)) begin
        err_overrun <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (eoc_edge_s && in_range_s) begin
            daddr_out <= {2'b00, channel_in};
            slot_r    <= slot_s;
            den_out   <= 1'b1;
            state_r   <= S_REQ;
          end
        end
        S_REQ: begin
          tmo_cnt_r <= '0;
          state_r   <= S_WAIT;
        end
        S_WAIT: begin
          if (drdy_in) begin
            sample_r <= do_in[15 -: OUT_W];
            state_r  <= S_ACCUM;
          end else if (tmo_cnt_r == TMO_LAST) begin
            err_timeout <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        S_ACCUM: begin
          if (cnt_r[slot_r] == CNT_LAST) begin
            result_r[slot_r] <= avg_s;
            acc_r[slot_r]    <= '0;
            cnt_r[slot_r]    <= '0;
            valid_r[slot_r]  <= 1'b1;
            sample_strobe    <= 1'b1;
            sample_ch        <= slot_r;
          end else begin
            acc_r[slot_r] <= sum_s;
            cnt_r[slot_r] <= cnt_r[slot_r] + CNT_W'(1);
          end
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Present the selected slot; indices past the last slot read as empty.
  always_comb begin
    sel_value = '0;
    sel_valid = 1'b0;
    if (int'(sel_ch) < NUM_CH) begin
      sel_value = result_r[sel_ch];
      sel_valid = valid_r[sel_ch];
    end else begin
      sel_value = '0;
      sel_valid = 1'b0;
    end
  end

`ifdef ADC_PEAK_HOLD_EN
  logic [OUT_W-1:0] peak_r [NUM_CH];

  // Track the largest raw sample per slot; a clear request beats a same-cycle update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        peak_r[i] <= '0;
      end
    end else if (peak_clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        peak_r[i] <= '0;
      end
    end else if ((state_r == S_ACCUM) && (sample_r > peak_r[slot_r])) begin
      peak_r[slot_r] <= sample_r;
    end
  end

  // Peak of the selected slot, empty for indices past the last slot.
  always_comb begin
    sel_peak = '0;
    if (int'(sel_ch) < NUM_CH) begin
      sel_peak = peak_r[sel_ch];
    end else begin
      sel_peak = '0;
    end
  end
`endif

endmodule

// File: tb/tb_adc_multi_ch_avg.sv
// Directed + randomized bench for adc_multi_ch_avg. The main instance uses the
// default 4-slot, 4-sample build. A second single-slot pass-through instance
// shares the stimulus and is checked on channel-22 reads.
module tb_adc_multi_ch_avg;

  logic        clk = 1'b0;
  logic        rstn;
  logic        eoc_in;
  logic [4:0]  channel_in;
  logic        drdy_in;
  logic [15:0] do_in;
  logic [1:0]  sel_ch;

  logic        den_out, sel_valid, sample_strobe, err_timeout, err_overrun;
  logic [6:0]  daddr_out;
  logic [11:0] sel_value;
  logic [1:0]  sample_ch;

  logic        pt_sel_ch;
  logic        pt_den_out, pt_sel_valid, pt_sample_strobe, pt_err_timeout, pt_err_overrun;
  logic [6:0]  pt_daddr_out;
  logic [11:0] pt_sel_value;
  logic        pt_sample_ch;

  always #5 clk = ~clk;

  adc_multi_ch_avg u_dut (
    .clk(clk), .rstn(rstn), .eoc_in(eoc_in), .channel_in(channel_in),
    .den_out(den_out), .daddr_out(daddr_out), .drdy_in(drdy_in), .do_in(do_in),
    .sel_ch(sel_ch), .sel_value(sel_value), .sel_valid(sel_valid),
    .sample_strobe(sample_strobe), .sample_ch(sample_ch),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  adc_multi_ch_avg #(.NUM_CH(1), .CH_BASE(5'd22), .OUT_W(12), .AVG_LOG2(0),
                     .TIMEOUT(64), .CH_W(1)) u_pt (
    .clk(clk), .rstn(rstn), .eoc_in(eoc_in), .channel_in(channel_in),
    .den_out(pt_den_out), .daddr_out(pt_daddr_out), .drdy_in(drdy_in), .do_in(do_in),
    .sel_ch(pt_sel_ch), .sel_value(pt_sel_value), .sel_valid(pt_sel_valid),
    .sample_strobe(pt_sample_strobe), .sample_ch(pt_sample_ch),
    .err_timeout(pt_err_timeout), .err_overrun(pt_err_overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int den_seen = 0;
  int den_exp  = 0;

  // Reference model: running sum and count per slot, average by integer division.
  int m_sum [4];
  int m_n   [4];
  int m_res [4];
  bit m_vld [4];
  bit e_tmo, e_ovr;

  always @(negedge clk) if (den_out === 1'b1) den_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 4; s++) begin
      m_sum[s] = 0; m_n[s] = 0; m_res[s] = 0; m_vld[s] = 1'b0;
    end
    e_tmo = 1'b0; e_ovr = 1'b0;
  endtask

  task automatic check_slots();
    for (int s = 0; s < 4; s++) begin
      sel_ch = 2'(s);
      #1;
      check($sformatf("sel_valid[%0d]", s), 32'(sel_valid), 32'(m_vld[s]));
      check($sformatf("sel_value[%0d]", s), 32'(sel_value), 32'(m_res[s]));
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_den", 32'(den_out), 0);
    check("rst_daddr", 32'(daddr_out), 0);
    check("rst_strobe", 32'(sample_strobe), 0);
    check("rst_sample_ch", 32'(sample_ch), 0);
    check("rst_err_timeout", 32'(err_timeout), 0);
    check("rst_err_overrun", 32'(err_overrun), 0);
    check("rst_sel_valid", 32'(sel_valid), 0);
    check("rst_sel_value", 32'(sel_value), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic start_req(input logic [4:0] ch);
    @(negedge clk);
    eoc_in = 1'b1; channel_in = ch;
    @(negedge clk);
    check("den_pulse", 32'(den_out), 1);
    check("daddr", 32'(daddr_out), 32'({2'b00, ch}));
    if (ch == 5'd22) check("pt_den_pulse", 32'(pt_den_out), 1);
    eoc_in = 1'b0;
    den_exp++;
  endtask

  task automatic do_read(input logic [4:0] ch, input logic [15:0] dv, input int dly, input bit ovr);
    int slot;
    bit strb;
    int s;
    slot = int'(ch) - 22;
    s = int'(dv) / 16;
    start_req(ch);
    if (ovr) begin
      @(negedge clk);
      eoc_in = 1'b1;
      @(negedge clk);
      eoc_in = 1'b0;
      e_ovr = 1'b1;
    end
    repeat (dly) @(negedge clk);
    drdy_in = 1'b1; do_in = dv;
    @(negedge clk);
    drdy_in = 1'b0; do_in = 16'($urandom);
    @(negedge clk);
    m_sum[slot] += s;
    m_n[slot]++;
    strb = 1'b0;
    if (m_n[slot] == 4) begin
      m_res[slot] = m_sum[slot] / 4;
      m_vld[slot] = 1'b1;
      m_sum[slot] = 0;
      m_n[slot]   = 0;
      strb = 1'b1;
    end
    check("sample_strobe", 32'(sample_strobe), 32'(strb));
    if (strb) check("sample_ch", 32'(sample_ch), 32'(slot));
    if (ch == 5'd22) begin
      check("pt_sel_value", 32'(pt_sel_value), 32'(s));
      check("pt_sel_valid", 32'(pt_sel_valid), 1);
      check("pt_strobe", 32'(pt_sample_strobe), 1);
      check("pt_err_timeout", 32'(pt_err_timeout), 0);
    end
    check_slots();
    check("den_count", 32'(den_seen), 32'(den_exp));
    check("err_timeout", 32'(err_timeout), 32'(e_tmo));
    check("err_overrun", 32'(err_overrun), 32'(e_ovr));
    @(negedge clk);
    check("strobe_one_cycle", 32'(sample_strobe), 0);
  endtask

  function automatic logic [15:0] mk(input int v);
    logic [15:0] r;
    r = {12'(v), 4'($urandom_range(0, 15))};
    return r;
  endfunction

  initial begin
    logic [4:0] rch;
    rstn = 1'b0; eoc_in = 1'b0; channel_in = 5'd0; drdy_in = 1'b0;
    do_in = 16'd0; sel_ch = 2'd0; pt_sel_ch = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rstn = 1'b1;

    // Pass-through on the single-slot instance; main instance holds a partial sum.
    do_read(5'd22, 16'hABC0, 3, 1'b0);
    pulse_reset();

    // Averaging on slot 1: 100, 200, 300, 401 -> 250.
    do_read(5'd23, mk(100), 2, 1'b0);
    do_read(5'd23, mk(200), 1, 1'b0);
    do_read(5'd23, mk(300), 4, 1'b0);
    do_read(5'd23, mk(401), 2, 1'b0);

    // Interleave slots 0/1 with constant values.
    for (int i = 0; i < 4; i++) begin
      do_read(5'd22, mk(10), 1 + i, 1'b0);
      do_read(5'd23, mk(40), 2, 1'b0);
    end

    // Timeout: drdy never arrives; flag rises exactly after the 64th wait cycle.
    start_req(5'd23);
    repeat (64) @(negedge clk);
    check("timeout_early", 32'(err_timeout), 0);
    @(negedge clk);
    check("timeout_set", 32'(err_timeout), 1);
    e_tmo = 1'b1;
    do_read(5'd23, mk(777), 2, 1'b0);

    // Overrun: second edge during WAIT is dropped.
    do_read(5'd22, mk(55), 3, 1'b1);

    // Out-of-range channels, including both window neighbours.
    foreach (rch[i]) begin end
    for (int k = 0; k < 3; k++) begin
      rch = (k == 0) ? 5'd3 : ((k == 1) ? 5'd21 : 5'd26);
      @(negedge clk);
      eoc_in = 1'b1; channel_in = rch;
      @(negedge clk);
      eoc_in = 1'b0;
      repeat (3) @(negedge clk);
      check("oor_no_den", 32'(den_seen), 32'(den_exp));
    end

    // Randomized traffic over all slots.
    for (int i = 0; i < 40; i++) begin
      rch = 5'(22 + $urandom_range(0, 3));
      do_read(rch, 16'($urandom), int'($urandom_range(1, 8)), 1'b0);
    end

    // Reset in WAIT with two samples accumulated on slot 2.
    pulse_reset();
    do_read(5'd24, mk(1000), 1, 1'b0);
    do_read(5'd24, mk(2000), 1, 1'b0);
    start_req(5'd24);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) do_read(5'd24, mk(100 * (i + 1)), 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_multi_ch_avg.md
Name: adc_multi_ch_avg

Overview:
- Parametrised successor to the single-channel XADC readout path.
- Services the XADC Wizard in channel-sequencer mode.
- On each end-of-conversion it runs a DRP read handshake for the reported channel and truncates the sample to OUT_W bits.
- Keeps a power-of-two block average per auxiliary channel, and presents any selected channel's latest average to downstream display/BCD logic.

Parameters:
- NUM_CH, 4, number of consecutive auxiliary channels serviced (1..16).
- CH_BASE, 5'd22, XADC channel address of slot 0 (VAUX6 = 16+6).
- OUT_W, 12, result width, taken from do_in MSBs (1..12).
- AVG_LOG2, 2, log2 of samples per average (0 = pass-through, max 6).
- TIMEOUT, 64, cycles allowed between den_out and drdy_in.
- CH_W, 2, width of slot index; must satisfy 2^CH_W >= NUM_CH.

Ports:
- clk  in  1  system clock; also the DRP clock.
- rstn  in  1  asynchronous active-low reset.
- eoc_in  in  1  XADC eoc_out.
- channel_in  in  5  XADC channel_out.
- den_out  out  1  DRP enable, one-cycle pulse.
- daddr_out  out  7  DRP address, {2'b00, latched channel}.
- drdy_in  in  1  XADC drdy_out.
- do_in  in  16  XADC do_out.
- sel_ch  in  CH_W  slot index whose result is presented.
- sel_value  out  OUT_W  averaged result of slot sel_ch.
- sel_valid  out  1  slot sel_ch has produced at least one average.
- sample_strobe  out  1  one-cycle pulse when any slot's average updates.
- sample_ch  out  CH_W  slot that produced the last update.
- err_timeout  out  1  sticky; a DRP read exceeded TIMEOUT.
- err_overrun  out  1  sticky; an eoc edge arrived while busy.

Behaviour:
- Reset (rstn low, asynchronous):
  - State returns to IDLE.
  - All accumulators, sample counters, results and valid bits clear.
  - den_out, sample_strobe, err_* go to 0; daddr_out, sample_ch go to 0.
- eoc_in is registered once (eoc_d). The edge condition is eoc_in & ~eoc_d.
- FSM states: IDLE, REQ, WAIT, ACCUM.
- IDLE:
  - On an edge with channel_in in [CH_BASE, CH_BASE+NUM_CH-1], latch channel_in and slot = channel_in - CH_BASE, then go to REQ.
  - Out-of-range channel: ignore and stay in IDLE.
- REQ (exactly one cycle):
  - den_out = 1; daddr_out = {2'b00, channel}.
  - Clear the timeout counter and go to WAIT.
  - den_out is therefore high in the cycle after the clock edge that detected the eoc edge.
- WAIT:
  - On drdy_in = 1, capture sample = do_in[15 -: OUT_W] and go to ACCUM.
  - The counter increments each cycle. At count TIMEOUT-1 without drdy_in, set err_timeout, discard the request and go to IDLE.
- ACCUM (one cycle):
  - acc[slot] += sample. acc width is OUT_W+AVG_LOG2, so overflow is impossible.
  - cnt[slot] += 1.
  - If cnt[slot] was 2^AVG_LOG2-1:
    - result[slot] = (acc[slot]+sample) >> AVG_LOG2.
    - acc[slot] = 0, cnt[slot] = 0, valid[slot] = 1.
    - sample_strobe = 1 on the next cycle; sample_ch = slot.
  - Then go to IDLE.
- AVG_LOG2 = 0: every sample writes result directly.
- Busy handling: an eoc edge in REQ, WAIT or ACCUM sets err_overrun and is dropped; there is no queueing.
- Error flags: both err_* are sticky and clear only on reset.
- sel_value/sel_valid: combinational mux of result[sel_ch]/valid[sel_ch]. A sel_ch >= NUM_CH yields value 0 and valid 0.
- Slots are fully independent; a partial accumulation in one slot is unaffected by traffic on others.
- Latency from drdy_in to the updated result being visible on sel_value: 2 clocks.

Optional Feature:
- Macro: ADC_PEAK_HOLD_EN.
- When defined:
  - Adds per-slot peak registers, updated in ACCUM with max(peak, sample) using the raw (unaveraged) sample.
  - Adds output port sel_peak [OUT_W] (peak of sel_ch).
  - Adds input port peak_clr [1], which zeroes all peaks synchronously. Within that cycle, peak_clr wins over an update.
- When undefined: no peak registers and neither port exists; all other behaviour is identical.

Test Plan:
- Single-slot pass-through:
  - Setup: AVG_LOG2=0, NUM_CH=1, CH_BASE=22.
  - Stimulus: eoc edge with channel_in=22; drdy_in 3 cycles after den_out with do_in=16'hABC0.
  - Required: den_out one pulse with daddr_out=7'h16; sel_value=12'hABC, sel_valid=1; sample_strobe pulses once.
- Averaging:
  - Setup: AVG_LOG2=2.
  - Stimulus: four reads on slot 1 with do_in MSB12 = 100, 200, 300, 401.
  - Required: sel_value stays invalid until the 4th read, then becomes 250 (1001>>2), sample_ch=1.
- Interleave:
  - Stimulus: alternating channels 22/23 with 4 samples each (10 for ch22, 40 for ch23).
  - Required: slot0 result 10, slot1 result 40, with no cross-contamination.
- Timeout:
  - Stimulus: den_out issued, drdy_in held 0 for 64 cycles.
  - Required: err_timeout=1; FSM returns to IDLE; the next valid eoc read succeeds.
- Overrun and out-of-range:
  - Stimulus: eoc edge during WAIT.
  - Required: err_overrun=1 and no extra den_out.
  - Stimulus: channel_in=5'd3 edge.
  - Required: no den_out.
- Reset mid-operation:
  - Stimulus: assert rstn low while in WAIT with 2 of 4 samples accumulated.
  - Required: all outputs 0, then a fresh 4 samples are needed before sel_valid=1.
